apb_master_module: RTL and testbench

APB_MASTER_MODULE -- requirements
Module: apb_master_module

---
 rtl/apb_pkg.sv | 25 ++
 rtl/apb_timeout_counter.sv | 45 ++++
 rtl/apb_master_module.sv | 178 +++++++++++++++++
 tb/tb_apb_master_module.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared types and widths for the APB master slice.
//                apb_state_t : transfer phase (IDLE, SETUP, ACCESS)
//                APB_ADDR_W  : APB address width
//                APB_DATA_W  : APB data width
//                APB_CNT_W   : wait-state counter width
//  Revision    : 1.0  initial release
// ============================================================================
package apb_pkg;

    localparam int APB_ADDR_W = 3;
    localparam int APB_DATA_W = 8;
    localparam int APB_CNT_W  = 8;

    // The fourth encoding (2'b11) is unreachable and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_t;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : apb_timeout_counter
//  Description : Wait-state counter for the APB ACCESS phase.
//                pclk     : clock
//                preset_n : async active-low reset
//                clear    : zero the count (takes priority over enable)
//                enable   : count one wait cycle
//                limit    : wait cycles allowed before abort
//                expired  : the cycle being counted now reaches the limit
//  Revision    : 1.0  initial release
// ============================================================================
module apb_timeout_counter
    import apb_pkg::*;
(
    input  logic                 pclk,
    input  logic                 preset_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [APB_CNT_W-1:0] limit,
    output logic                 expired
);

    logic [APB_CNT_W-1:0] r_count;
    logic [APB_CNT_W:0]   w_count_inc;

    // One bit wider so the comparison cannot wrap at a limit of 255.
    assign w_count_inc = {1'b0, r_count} + {{APB_CNT_W{1'b0}}, 1'b1};

    // Flags the wait cycle that makes the count hit the limit, so the
    // master leaves ACCESS after exactly 'limit' wait cycles.
    assign expired = enable && (w_count_inc >= {1'b0, limit});

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_count_inc[APB_CNT_W-1:0];
        end
    end

endmodule : apb_timeout_counter
`default_nettype wire

// File: rtl/apb_master_module.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_module
//  Description : Single-outstanding APB master with wait-state timeout.
//                Local side : cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata
//                             rsp_valid/rsp_rdata/rsp_err/rsp_timeout
//                APB side   : psel_x/penable/pwrite/paddr/pwdata
//                             prdata/pready/pslverr
//                Parameter  : TIMEOUT_CYCLES (1..255) wait cycles before abort
//  Revision    : 1.0  initial release
// ============================================================================
module apb_master_module
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
)
(
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [APB_ADDR_W-1:0] cmd_addr,
    input  logic [APB_DATA_W-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel_x,
    output logic                  penable,
    output logic                  pwrite,
    output logic [APB_ADDR_W-1:0] paddr,
    output logic [APB_DATA_W-1:0] pwdata,
    input  logic [APB_DATA_W-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam logic [APB_CNT_W-1:0] c_limit = TIMEOUT_CYCLES[APB_CNT_W-1:0];

    apb_state_t            r_state;
    apb_state_t            w_state_next;

    logic                  r_write;
    logic [APB_ADDR_W-1:0] r_addr;
    logic [APB_DATA_W-1:0] r_wdata;

    logic                  r_rsp_valid;
    logic [APB_DATA_W-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;

    logic                  w_accept;
    logic                  w_done_ok;
    logic                  w_done_to;
    logic                  w_wait;
    logic                  w_expired;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and phase outputs (decoded from state only, so reset
    // drops psel_x/penable in the same instant)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done_ok    = 1'b0;
        w_done_to    = 1'b0;
        cmd_ready    = 1'b0;
        psel_x       = 1'b0;
        penable      = 1'b0;
        unique case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = SETUP;
                end
            end
            SETUP: begin
                psel_x       = 1'b1;
                w_state_next = ACCESS;
            end
            ACCESS: begin
                psel_x  = 1'b1;
                penable = 1'b1;
                // pready is tested first so a completion in the limit
                // cycle is reported as a normal response.
                if (pready) begin
                    w_done_ok    = 1'b1;
                    w_state_next = IDLE;
                end else if (w_expired) begin
                    w_done_to    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Wait-state counter: zeroed as SETUP is entered, counts stalled
    // ACCESS cycles.
    // ------------------------------------------------------------------
    assign w_wait = (r_state == ACCESS) && !pready;

    apb_timeout_counter u_timeout_counter (
        .pclk     (pclk),
        .preset_n (preset_n),
        .clear    (w_accept),
        .enable   (w_wait),
        .limit    (c_limit),
        .expired  (w_expired)
    );

    // ------------------------------------------------------------------
    // Command holding registers; only loaded on accept so the APB
    // address/data stay frozen through SETUP/ACCESS and after.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_write <= cmd_write;
            r_addr  <= cmd_addr;
            // Reads drive zero on pwdata.
            r_wdata <= cmd_write ? cmd_wdata : '0;
        end
    end

    assign pwrite = r_write;
    assign paddr  = r_addr;
    assign pwdata = r_wdata;

    // ------------------------------------------------------------------
    // Response registers: one-cycle valid pulse, payload held between.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= w_done_ok || w_done_to;
            if (w_done_ok) begin
                r_rsp_rdata   <= r_write ? '0 : prdata;
                r_rsp_err     <= pslverr;
                r_rsp_timeout <= 1'b0;
            end else if (w_done_to) begin
                r_rsp_rdata   <= '0;
                r_rsp_err     <= 1'b1;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule : apb_master_module
`default_nettype wire

// File: tb/tb_apb_master_module.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master_module
//  Description : Directed self-checking bench for apb_master_module
//                (TIMEOUT_CYCLES = 4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_apb_master_module;

    logic       pclk;
    logic       preset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic       psel_x;
    logic       penable;
    logic       pwrite;
    logic [2:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    int n_chk;
    int n_err;

    apb_master_module #(.TIMEOUT_CYCLES(4)) dut (
        .pclk        (pclk),
        .preset_n    (preset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel_x      (psel_x),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_apb(input string tag, input logic s, input logic e,
                             input logic [2:0] a, input logic w, input logic [7:0] d);
        check_eq({tag, ".psel"},    32'(psel_x),  32'(s));
        check_eq({tag, ".penable"}, 32'(penable), 32'(e));
        check_eq({tag, ".paddr"},   32'(paddr),   32'(a));
        check_eq({tag, ".pwrite"},  32'(pwrite),  32'(w));
        check_eq({tag, ".pwdata"},  32'(pwdata),  32'(d));
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [7:0] d,
                             input logic err, input logic to);
        check_eq({tag, ".rsp_valid"},   32'(rsp_valid),   32'(v));
        check_eq({tag, ".rsp_rdata"},   32'(rsp_rdata),   32'(d));
        check_eq({tag, ".rsp_err"},     32'(rsp_err),     32'(err));
        check_eq({tag, ".rsp_timeout"}, 32'(rsp_timeout), 32'(to));
    endtask

    // Advance one clock; everything after this is 1 time unit past the edge.
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [2:0] a, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk     = 0;
        n_err     = 0;
        preset_n  = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 3'h0;
        cmd_wdata = 8'h00;
        prdata    = 8'h00;
        pready    = 1'b0;
        pslverr   = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        check_eq("rst.cmd_ready", 32'(cmd_ready), 32'h1);
        check_apb("rst", 1'b0, 1'b0, 3'h0, 1'b0, 8'h00);
        check_rsp("rst", 1'b0, 8'h00, 1'b0, 1'b0);
        preset_n = 1'b1;
        step();

        // ---------------- write 0x2 <= 0xA5, zero wait ----------------
        issue(1'b1, 3'h2, 8'hA5);
        pready = 1'b1;
        #1;
        check_eq("wr.idle_ready", 32'(cmd_ready), 32'h1);
        step();                                   // SETUP
        cmd_valid = 1'b0;
        #1;
        check_eq("wr.setup_ready", 32'(cmd_ready), 32'h0);
        check_apb("wr.setup", 1'b1, 1'b0, 3'h2, 1'b1, 8'hA5);
        step();                                   // ACCESS
        check_apb("wr.access", 1'b1, 1'b1, 3'h2, 1'b1, 8'hA5);
        step();                                   // IDLE, response
        check_apb("wr.done", 1'b0, 1'b0, 3'h2, 1'b1, 8'hA5);
        check_rsp("wr.rsp", 1'b1, 8'h00, 1'b0, 1'b0);
        step();
        check_eq("wr.pulse_end", 32'(rsp_valid), 32'h0);

        // ---------------- read 0x5, 3 wait states ----------------
        issue(1'b0, 3'h5, 8'hEE);                 // wdata must not appear on pwdata
        step();                                   // SETUP
        cmd_valid = 1'b0;
        pready    = 1'b0;
        prdata    = 8'h99;
        #1;
        check_apb("rd.setup", 1'b1, 1'b0, 3'h5, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();                               // ACCESS cycles 1..3, stalled
            check_apb("rd.wait", 1'b1, 1'b1, 3'h5, 1'b0, 8'h00);
            check_eq("rd.wait_rsp", 32'(rsp_valid), 32'h0);
        end
        step();                                   // ACCESS 4 = limit cycle, pready wins
        pready = 1'b1;
        prdata = 8'h3C;
        #1;
        check_apb("rd.access4", 1'b1, 1'b1, 3'h5, 1'b0, 8'h00);
        step();
        check_rsp("rd.rsp", 1'b1, 8'h3C, 1'b0, 1'b0);
        check_eq("rd.psel_off", 32'(psel_x), 32'h0);

        // ---------------- read with pslverr ----------------
        issue(1'b0, 3'h1, 8'h00);
        prdata  = 8'h77;
        pslverr = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        check_rsp("err.rsp", 1'b1, 8'h77, 1'b1, 1'b0);
        pslverr = 1'b0;
        step();
        check_rsp("err.hold", 1'b0, 8'h77, 1'b1, 1'b0);

        // ---------------- timeout ----------------
        issue(1'b0, 3'h3, 8'h00);
        pready = 1'b0;
        prdata = 8'hFF;
        step();                                   // SETUP
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();                               // ACCESS cycles 1..4
            check_eq("to.penable", 32'(penable), 32'h1);
        end
        step();                                   // aborted
        check_apb("to.done", 1'b0, 1'b0, 3'h3, 1'b0, 8'h00);
        check_rsp("to.rsp", 1'b1, 8'h00, 1'b1, 1'b1);
        check_eq("to.ready", 32'(cmd_ready), 32'h1);

        // ---------------- back-to-back with cmd_valid held ----------------
        issue(1'b1, 3'h1, 8'h11);
        pready = 1'b1;
        step();                                   // SETUP with cmd 1
        issue(1'b1, 3'h6, 8'h22);                 // second command waiting
        #1;
        check_eq("b2b.setup_ready", 32'(cmd_ready), 32'h0);
        check_apb("b2b.setup1", 1'b1, 1'b0, 3'h1, 1'b1, 8'h11);
        step();                                   // ACCESS cmd 1
        check_eq("b2b.access_ready", 32'(cmd_ready), 32'h0);
        check_apb("b2b.access1", 1'b1, 1'b1, 3'h1, 1'b1, 8'h11);
        step();                                   // IDLE + rsp, second accepted here
        check_eq("b2b.rsp_valid", 32'(rsp_valid), 32'h1);
        check_eq("b2b.rsp_ready", 32'(cmd_ready), 32'h1);
        check_eq("b2b.rsp_err", 32'(rsp_err), 32'h0);
        check_eq("b2b.rsp_timeout", 32'(rsp_timeout), 32'h0);
        step();                                   // SETUP cmd 2
        cmd_valid = 1'b0;
        #1;
        check_apb("b2b.setup2", 1'b1, 1'b0, 3'h6, 1'b1, 8'h22);
        step();
        step();
        check_eq("b2b.rsp2", 32'(rsp_valid), 32'h1);

        // ---------------- reset mid-ACCESS ----------------
        step();
        issue(1'b0, 3'h4, 8'h00);
        pready = 1'b0;
        step();                                   // SETUP
        cmd_valid = 1'b0;
        step();                                   // ACCESS
        check_eq("rstm.in_access", 32'(penable), 32'h1);
        preset_n = 1'b0;
        #1;
        check_apb("rstm.now", 1'b0, 1'b0, 3'h0, 1'b0, 8'h00);
        check_eq("rstm.ready", 32'(cmd_ready), 32'h1);
        pready = 1'b1;
        step();
        check_eq("rstm.no_rsp", 32'(rsp_valid), 32'h0);
        preset_n = 1'b1;
        step();
        check_eq("rstm.no_rsp2", 32'(rsp_valid), 32'h0);
        check_eq("rstm.ready_after", 32'(cmd_ready), 32'h1);
        check_eq("rstm.psel_after", 32'(psel_x), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_apb_master_module
`default_nettype wire
